// File: rtl/fma_wb_packer_if.sv
// Handshake bundle for fma_wb_packer: vector input stream plus SRAM write port.
// The slave modport is the packer's view; master is the producer/SRAM side.
interface fma_wb_packer_if #(
  parameter int unsigned BwFp         = 17,
  parameter int unsigned ValueMn      = 64,
  parameter int unsigned LanesPerBeat = 16,
  parameter int unsigned BwAddr       = 10
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ValueMn*BwFp-1:0]      in_data;
  logic                         wr_ready;
  logic                         wr_en;
  logic [BwAddr-1:0]            wr_addr;
  logic [LanesPerBeat*BwFp-1:0] wr_data;

  modport master (
    output in_valid,
    output in_data,
    output wr_ready,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  wr_ready,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/fma_wb_packer.sv
// Writeback packer: buffers result vectors in a 2-deep FIFO and writes them to SRAM as beats.
// Define FMA_WB_SAT_EN to clamp Inf/NaN lanes to the largest finite value of the same sign.
module fma_wb_packer #(
  parameter int unsigned BwFp         = 17,
  parameter int unsigned ValueMn      = 64,
  parameter int unsigned LanesPerBeat = 16,
  parameter int unsigned BwAddr       = 10,
  parameter int unsigned BwCnt        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [BwAddr-1:0] base_addr_i,
  input  logic [BwCnt-1:0]  num_vec_i,
  output logic              busy_o,
  output logic              done_o,
  fma_wb_packer_if.slave    bus
);

  localparam int unsigned Beats     = ValueMn / LanesPerBeat;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned VecW      = ValueMn * BwFp;
  localparam int unsigned BeatDataW = LanesPerBeat * BwFp;
  localparam int unsigned ManW      = 8;
  localparam int unsigned ExpW      = 8;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [BwAddr-1:0] addr_q, addr_d;
  logic [BwCnt-1:0]  num_q, num_d;
  logic [BwCnt-1:0]  acc_q, acc_d;
  logic [BwCnt-1:0]  wcnt_q, wcnt_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [VecW-1:0]   mem_q [2];

  logic                 fifo_full, fifo_empty;
  logic                 in_ready, push, wr_en, beat_fire, last_beat, pop;
  logic [BwCnt-1:0]     wcnt_inc;
  logic [VecW-1:0]      head;
  logic [BeatDataW-1:0] head_beats [Beats];
  logic [BeatDataW-1:0] beat_raw;
  logic [BeatDataW-1:0] beat_out;

  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);

  // in_ready is a pure function of registered state; no in_valid feedback.
  assign in_ready  = (state_q == StRun) && !fifo_full && (acc_q < num_q);
  assign push      = bus.in_valid && in_ready;
  assign wr_en     = (state_q == StRun) && !fifo_empty;
  assign beat_fire = wr_en && bus.wr_ready;
  assign last_beat = (beat_q == BeatW'(Beats - 1));
  assign pop       = beat_fire && last_beat;
  assign wcnt_inc  = wcnt_q + BwCnt'(1);

  assign head = mem_q[rd_ptr_q];

  for (genvar b = 0; b < Beats; b++) begin : g_beat
    assign head_beats[b] = head[b*BeatDataW +: BeatDataW];
  end

  assign beat_raw = head_beats[beat_q];

  for (genvar l = 0; l < LanesPerBeat; l++) begin : g_lane
    logic [BwFp-1:0] lane;
    assign lane = beat_raw[l*BwFp +: BwFp];
`ifdef FMA_WB_SAT_EN
    assign beat_out[l*BwFp +: BwFp] = (lane[ManW +: ExpW] == {ExpW{1'b1}}) ?
                                      {lane[BwFp-1], 8'hFE, 8'hFF} : lane;
`else
    assign beat_out[l*BwFp +: BwFp] = lane;
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    num_d    = num_q;
    acc_d    = acc_q;
    wcnt_d   = wcnt_q;
    beat_d   = beat_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          num_d    = num_vec_i;
          acc_d    = '0;
          wcnt_d   = '0;
          beat_d   = '0;
          rd_ptr_d = 1'b0;
          wr_ptr_d = 1'b0;
          cnt_d    = '0;
          state_d  = (num_vec_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (push) begin
          wr_ptr_d = ~wr_ptr_q;
          acc_d    = acc_q + BwCnt'(1);
        end
        if (beat_fire) begin
          addr_d = addr_q + BwAddr'(1);
          beat_d = last_beat ? '0 : beat_q + BeatW'(1);
        end
        if (pop) begin
          rd_ptr_d = ~rd_ptr_q;
          wcnt_d   = wcnt_inc;
          if (wcnt_inc == num_q) begin
            state_d = StDone;
          end
        end
        unique case ({push, pop})
          2'b10:   cnt_d = cnt_q + 2'd1;
          2'b01:   cnt_d = cnt_q - 2'd1;
          default: cnt_d = cnt_q;
        endcase
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      num_q    <= '0;
      acc_q    <= '0;
      wcnt_q   <= '0;
      beat_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      num_q    <= num_d;
      acc_q    <= acc_d;
      wcnt_q   <= wcnt_d;
      beat_q   <= beat_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is reset so wr_data reads zero out of reset and after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = beat_out;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);

`ifndef SYNTHESIS
  stall_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.wr_en && !bus.wr_ready) |=>
      (bus.wr_en && $stable(bus.wr_addr) && $stable(bus.wr_data)));
`endif

endmodule

// File: tb/tb_fma_wb_packer.sv
// Self-checking bench for fma_wb_packer: a queue-based model of the expected SRAM write
// stream checked every cycle, plus literal expectations per directed job.
`timescale 1ns/1ps
module tb_fma_wb_packer;
  localparam int unsigned BwFp         = 17;
  localparam int unsigned ValueMn      = 64;
  localparam int unsigned LanesPerBeat = 16;
  localparam int unsigned BwAddr       = 10;
  localparam int unsigned BwCnt        = 8;
  localparam int unsigned Beats        = ValueMn / LanesPerBeat;
  localparam int unsigned VW           = ValueMn * BwFp;
  localparam int unsigned DW           = LanesPerBeat * BwFp;

  typedef struct packed {
    logic [BwAddr-1:0] addr;
    logic [DW-1:0]     data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [BwAddr-1:0] base_addr = '0;
  logic [BwCnt-1:0]  num_vec = '0;
  logic              busy, done;

  fma_wb_packer_if #(
    .BwFp(BwFp), .ValueMn(ValueMn), .LanesPerBeat(LanesPerBeat), .BwAddr(BwAddr)
  ) ifc ();

  fma_wb_packer #(
    .BwFp(BwFp), .ValueMn(ValueMn), .LanesPerBeat(LanesPerBeat), .BwAddr(BwAddr),
    .BwCnt(BwCnt)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .base_addr_i(base_addr),
    .num_vec_i  (num_vec),
    .busy_o     (busy),
    .done_o     (done),
    .bus        (ifc.slave)
  );

  always #5 clk = ~clk;

  // Model state
  wr_t          exp_q[$];
  logic [VW-1:0] vecs [8];
  int  m_acc, m_pop, m_beats, m_num;
  bit  m_busy, m_done;
  // Bookkeeping
  int  n_pass, n_fail, n_checks, cyc;
  int  log_n, done_cyc, fall_cyc, start_cyc, acc_total;
  logic [BwAddr-1:0] log_addr [16];
  logic [DW-1:0]     log_data [16];
  int  log_cyc [16];
  bit  saw_full, stall_mode;
  int  stall_k;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [DW-1:0] sat_beat(input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = b;
`ifdef FMA_WB_SAT_EN
    for (int i = 0; i < LanesPerBeat; i++) begin
      if (b[i*BwFp+8 +: 8] == 8'hFF) r[i*BwFp +: BwFp] = {b[i*BwFp+16], 16'hFEFF};
    end
`endif
    return r;
  endfunction

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Compare process: every negedge, outputs against the model of the current cycle.
  initial begin
    bit  nx_busy, nx_done, exp_ir, exp_we;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_in_ready", ifc.in_ready, '0);
        check("rst_wr_en", ifc.wr_en, '0);
        check("rst_wr_addr", ifc.wr_addr, '0);
        check("rst_wr_data", ifc.wr_data, '0);
        check("rst_busy", busy, '0);
        check("rst_done", done, '0);
        exp_q.delete();
        m_acc = 0; m_pop = 0; m_beats = 0; m_num = 0; m_busy = 0; m_done = 0;
      end else begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        exp_ir = m_busy && !m_done && (m_acc - m_pop) < 2 && m_acc < m_num;
        exp_we = m_busy && !m_done && (m_acc - m_pop) > 0;
        check("in_ready", ifc.in_ready, exp_ir);
        check("wr_en", ifc.wr_en, exp_we);
        if (m_busy && !m_done && (m_acc - m_pop) == 2 && m_acc < m_num && !ifc.in_ready)
          saw_full = 1;
        nx_busy = m_busy;
        nx_done = 0;
        if (m_done) nx_busy = 0;
        if (ifc.wr_en && ifc.wr_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_write", ifc.wr_addr, ~ifc.wr_addr);
          end else begin
            check("wr_addr", ifc.wr_addr, exp_q[0].addr);
            check("wr_data", ifc.wr_data, exp_q[0].data);
            if (log_n < 16) begin
              log_addr[log_n] = ifc.wr_addr;
              log_data[log_n] = ifc.wr_data;
              log_cyc[log_n]  = cyc;
              log_n++;
            end
            void'(exp_q.pop_front());
            m_beats++;
            if (m_beats % Beats == 0) m_pop++;
            if (exp_q.size() == 0) nx_done = 1;
          end
        end
        if (done) done_cyc = cyc;
        if (m_done && !nx_busy) fall_cyc = cyc + 1;
        if (ifc.in_valid && ifc.in_ready) begin
          m_acc++;
          acc_total++;
        end
        if (start && !m_busy) begin
          nx_busy = 1;
          start_cyc = cyc;
          m_num = int'(num_vec);
          m_acc = 0; m_pop = 0; m_beats = 0;
          exp_q.delete();
          for (int v = 0; v < m_num; v++) begin
            for (int k = 0; k < Beats; k++) begin
              w.addr = BwAddr'(int'(num_vec) * 0 + int'(base_addr) + v * Beats + k);
              w.data = sat_beat(vecs[v][k*DW +: DW]);
              exp_q.push_back(w);
            end
          end
          if (num_vec == '0) nx_done = 1;
        end
        m_busy = nx_busy;
        m_done = nx_done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_mode) begin
      ifc.wr_ready = (stall_k % 4 == 0) || (stall_k % 4 == 3);
      stall_k++;
    end
    ifc.in_data = (m_acc < 8) ? vecs[m_acc] : '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: job still busy after %0d cycles", n);
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic launch(input logic [BwAddr-1:0] ba, input logic [BwCnt-1:0] nv);
    log_n = 0; done_cyc = -1; fall_cyc = -1; start_cyc = -1; acc_total = 0; saw_full = 0;
    ifc.in_data  = vecs[0];
    ifc.in_valid = 1'b1;
    base_addr    = ba;
    num_vec      = nv;
    start        = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_vecs(input int seed);
    for (int v = 0; v < 8; v++)
      for (int i = 0; i < ValueMn; i++)
        vecs[v][i*BwFp +: BwFp] = {1'b0, 8'(seed + v), 8'(i)};
  endtask

  initial begin
    int n;
    n_pass = 0; n_fail = 0; n_checks = 0;
    stall_mode = 0; stall_k = 0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    ifc.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Job 1: lane i holds value i
    for (int i = 0; i < ValueMn; i++) vecs[0][i*BwFp +: BwFp] = 17'(i);
    launch(10'h010, 8'd1);
    wait_idle();
    check("j1_writes", 32'(log_n), 32'd4);
    check("j1_addr0", log_addr[0], 10'h010);
    check("j1_addr3", log_addr[3], 10'h013);
    check("j1_b0_l0", log_data[0][16:0], 17'd0);
    check("j1_b2_l0", log_data[2][16:0], 17'd32);
    check("j1_b3_l15", log_data[3][15*BwFp +: BwFp], 17'd63);
    check("j1_done_cyc", 32'(done_cyc), 32'(log_cyc[3] + 1));
    check("j1_busy_fall", 32'(fall_cyc), 32'(log_cyc[3] + 2));

    // Job 2: three vectors back to back; a stray start mid-job is ignored
    fill_vecs(16);
    launch(10'h040, 8'd3);
    repeat (4) tick();
    num_vec = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    check("j2_writes", 32'(log_n), 32'd12);
    check("j2_no_gaps", 32'(log_cyc[11] - log_cyc[0]), 32'd11);
    check("j2_accepted", 32'(acc_total), 32'd3);
    check("j2_addr11", log_addr[11], 10'h04B);

    // Job 3: address wrap
    fill_vecs(40);
    launch(10'h3FE, 8'd1);
    wait_idle();
    check("j3_addr0", log_addr[0], 10'h3FE);
    check("j3_addr1", log_addr[1], 10'h3FF);
    check("j3_addr2", log_addr[2], 10'h000);
    check("j3_addr3", log_addr[3], 10'h001);

    // Job 4: wr_ready pattern 1,0,0,1
    fill_vecs(60);
    stall_mode = 1; stall_k = 0;
    launch(10'h080, 8'd3);
    wait_idle();
    stall_mode = 0;
    ifc.wr_ready = 1'b1;
    check("j4_writes", 32'(log_n), 32'd12);
    check("j4_accepted", 32'(acc_total), 32'd3);
    check("j4_fifo_full", 32'(saw_full), 32'd1);

    // Job 5: Inf/NaN lanes
    fill_vecs(80);
    vecs[0][5*BwFp +: BwFp] = 17'h1FF00;
    vecs[0][6*BwFp +: BwFp] = 17'h0FF12;
    launch(10'h200, 8'd1);
    wait_idle();
`ifdef FMA_WB_SAT_EN
    check("j5_lane5", log_data[0][5*BwFp +: BwFp], 17'h1FEFF);
    check("j5_lane6", log_data[0][6*BwFp +: BwFp], 17'h0FEFF);
`else
    check("j5_lane5", log_data[0][5*BwFp +: BwFp], 17'h1FF00);
    check("j5_lane6", log_data[0][6*BwFp +: BwFp], 17'h0FF12);
`endif

    // Job 6: reset after the 2nd beat, then a clean restart
    fill_vecs(100);
    launch(10'h050, 8'd2);
    n = 0;
    while (m_beats < 2 && n < 50) begin
      tick();
      n++;
    end
    check("j6_reached_beat2", 32'(m_beats), 32'd2);
    #2 rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    check("j6_abort_wr_en", ifc.wr_en, '0);
    check("j6_abort_busy", busy, '0);
    check("j6_abort_addr", ifc.wr_addr, '0);
    check("j6_abort_data", ifc.wr_data, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fill_vecs(120);
    launch(10'h100, 8'd1);
    wait_idle();
    check("j6_restart_n", 32'(log_n), 32'd4);
    check("j6_restart_addr", log_addr[0], 10'h100);

    // Job 7: empty job
    launch(10'h123, 8'd0);
    wait_idle();
    tick();
    check("j7_no_writes", 32'(log_n), 32'd0);
    check("j7_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
